// File: rtl/vga_timing_pkg.sv
`default_nettype none
// =============================================================================
// vga_timing_pkg : 640x480@60 raster timing constants and shared pixel types.
// Rev 1.0
// =============================================================================
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef logic [11:0] rgb_t;
  typedef logic [9:0]  coord_t;

endpackage
`default_nettype wire

// File: rtl/scan_delay_line.sv
`default_nettype none
// =============================================================================
// scan_delay_line : pixel-tick enabled shift register; DEPTH=0 is a pass-through.
// Rev 1.0
// =============================================================================
module scan_delay_line #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 0,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, tick};
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
        end else if (tick) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_scan_out.sv
`default_nettype none
// =============================================================================
// vga_scan_out : raster source for the pixel-query interface; samples pixel_on
// and drives aligned hsync/vsync/rgb. Optional macro SCAN_BLINK_EN. Rev 1.0
// =============================================================================
module vga_scan_out
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter int   PIPE_LAT = 0,
  parameter rgb_t FG_COLOR = 12'hFFF,
  parameter rgb_t BG_COLOR = 12'h000
`ifdef SCAN_BLINK_EN
  ,
  parameter int   BLINK_FRAMES = 30
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  x,
  output logic [9:0]  y,
  input  logic        pixel_on,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        active,
`ifdef SCAN_BLINK_EN
  input  logic        blink_en,
`endif
  output logic        frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // {hs_n, vs_n, active} as seen outside the sync and visible regions
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  logic [DIV_W-1:0] div;
  logic             tick;
  logic             line_end;
  logic             frame_end;
  logic             hs_raw_n;
  logic             vs_raw_n;
  logic             act_raw;
  logic [2:0]       dly_q;
  logic             pix_eff;

  assign tick      = (div == DIV_W'(CLK_DIV - 1));
  assign line_end  = (x == coord_t'(H_TOTAL - 1));
  assign frame_end = line_end && (y == coord_t'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      x   <= '0;
      y   <= '0;
    end else if (tick) begin
      div <= '0;
      if (line_end) begin
        x <= '0;
        y <= frame_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  assign hs_raw_n = !((x >= coord_t'(HS_START)) && (x < coord_t'(HS_END)));
  assign vs_raw_n = !((y >= coord_t'(VS_START)) && (y < coord_t'(VS_END)));
  assign act_raw  = (x < coord_t'(H_ACTIVE)) && (y < coord_t'(V_ACTIVE));

  // Sync/active follow the renderer latency so they land with their pixel_on
  scan_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_LAT),
    .INIT  (SYNC_IDLE)
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .d     ({hs_raw_n, vs_raw_n, act_raw}),
    .q     (dly_q)
  );

`ifdef SCAN_BLINK_EN
  logic [5:0] blink_cnt;
  logic       blink_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
    end else if (frame_start) begin
      blink_cnt <= (blink_cnt == 6'(2 * BLINK_FRAMES - 1)) ? '0 : blink_cnt + 1'b1;
    end
  end

  assign blink_mask = blink_en && (blink_cnt >= 6'(BLINK_FRAMES));
  assign pix_eff    = pixel_on && !blink_mask;
`else
  assign pix_eff    = pixel_on;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && frame_end;
      if (tick) begin
        hsync  <= dly_q[2];
        vsync  <= dly_q[1];
        active <= dly_q[0];
        rgb    <= dly_q[0] ? (pix_eff ? FG_COLOR : BG_COLOR) : '0;
      end
    end
  end

endmodule
`default_nettype wire
